// File: rtl/miner_link_pkg.sv
// Shared constants and types for the miner host link: packet geometry and TX states.
package miner_link_pkg;

    localparam int WORK_BYTES     = 44;
    localparam int MIDSTATE_BYTES = 32;
    localparam int NONCE_BYTES    = 4;
    localparam int DATA_BYTES     = WORK_BYTES - MIDSTATE_BYTES;
    localparam int NONCE_W        = NONCE_BYTES * 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/miner_work_link_nonce_fifo.sv
// Golden-nonce queue: power-of-two depth, wrap-bit pointers, drops pushes while full.
module nonce_fifo #(
    parameter int LOG2  = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             dropped
);

    localparam int DEPTH = 1 << LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2:0]    wr_ptr;
    logic [LOG2:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-pop pointers, so a push in a full cycle is lost even if a pop frees a slot.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {LOG2{1'b0}}});
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dropped = push & full;
    assign rdata   = mem[rd_ptr[LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/miner_work_link.sv
// Host link endpoint: assembles 44-byte work packets from RX bytes and streams queued golden nonces out little-endian.
//
//   state | meaning
//   IDLE  | no nonce in flight; pops the FIFO head as soon as one is queued
//   SEND  | presenting nonce byte tx_idx; advances on tx_valid & tx_ready
module miner_work_link
    import miner_link_pkg::*;
#(
    parameter int          FIFO_LOG2  = 2,
    parameter logic [23:0] RX_TIMEOUT = 24'd1_000_000
) (
    input  logic          hash_clk,
    input  logic          reset,
    input  logic [7:0]    rx_byte,
    input  logic          rx_valid,
    output logic [255:0]  midstate,
    output logic [95:0]   data,
    output logic          work_valid,
    input  logic [31:0]   golden_nonce,
    input  logic          golden_valid,
    output logic [7:0]    tx_byte,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          overflow
);

    // The 44th byte completes the 352-bit image combinationally, so only 43 bytes are ever held.
    logic [(WORK_BYTES-1)*8-1:0] shadow;
    logic [WORK_BYTES*8-1:0]     shadow_next;
    logic [5:0]                  rx_count;
    logic [23:0]                 idle_timer;
    logic                        last_byte;
    logic                        rx_timeout;

    assign shadow_next = {shadow, rx_byte};
    assign last_byte   = rx_valid && (rx_count == 6'(WORK_BYTES - 1));
    assign rx_timeout  = !rx_valid && (rx_count != 6'd0) && (idle_timer == 24'd1);

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            rx_count   <= 6'd0;
            idle_timer <= RX_TIMEOUT;
            midstate   <= '0;
            data       <= '0;
            work_valid <= 1'b0;
        end else begin
            work_valid <= 1'b0;
            if (rx_valid) begin
                shadow     <= shadow_next[(WORK_BYTES-1)*8-1:0];
                idle_timer <= RX_TIMEOUT;
                if (last_byte) begin
                    rx_count   <= 6'd0;
                    midstate   <= shadow_next[WORK_BYTES*8-1 -: MIDSTATE_BYTES*8];
                    data       <= shadow_next[DATA_BYTES*8-1:0];
                    work_valid <= 1'b1;
                end else begin
                    rx_count <= rx_count + 6'd1;
                end
            end else begin
                if (idle_timer != 24'd0) idle_timer <= idle_timer - 24'd1;
                if (rx_timeout) rx_count <= 6'd0;
            end
        end
    end

    logic [NONCE_W-1:0] fifo_rdata;
    logic               fifo_empty;
    logic               fifo_dropped;
    logic               fifo_pop;

    nonce_fifo #(
        .LOG2  (FIFO_LOG2),
        .WIDTH (NONCE_W)
    ) u_nonce_fifo (
        .clk     (hash_clk),
        .rst     (reset),
        .push    (golden_valid),
        .wdata   (golden_nonce),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else if (fifo_dropped) overflow <= 1'b1;
    end

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [NONCE_W-1:0] tx_shift;
    logic [NONCE_W-1:0] tx_shift_nxt;
    logic [1:0]         tx_idx;
    logic [1:0]         tx_idx_nxt;
    logic               tx_valid_nxt;

    // The byte on the wire is always the low byte of the right-shifting nonce register.
    assign tx_byte = tx_shift[7:0];

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_shift <= '0;
            tx_idx   <= 2'd0;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_shift <= tx_shift_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_valid <= tx_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_shift_nxt = tx_shift;
        tx_idx_nxt   = tx_idx;
        tx_valid_nxt = tx_valid;
        fifo_pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    tx_shift_nxt = fifo_rdata;
                    tx_idx_nxt   = 2'd0;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (tx_idx == 2'(NONCE_BYTES - 1)) begin
                        tx_valid_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end else begin
                        tx_idx_nxt   = tx_idx + 2'd1;
                        tx_shift_nxt = {8'h00, tx_shift[NONCE_W-1:8]};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_miner_work_link.sv
// Self-checking bench for miner_work_link: queue-based packet/nonce model plus directed literal checks.
module tb_miner_work_link;

    localparam int          FL  = 2;
    localparam logic [23:0] TMO = 24'd16;

    logic         hash_clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_valid = 1'b0;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         work_valid;
    logic [31:0]  golden_nonce = 32'h0;
    logic         golden_valid = 1'b0;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         overflow;

    miner_work_link #(.FIFO_LOG2(FL), .RX_TIMEOUT(TMO)) dut (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .midstate     (midstate),
        .data         (data),
        .work_valid   (work_valid),
        .golden_nonce (golden_nonce),
        .golden_valid (golden_valid),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .overflow     (overflow)
    );

    always #5 hash_clk = ~hash_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: bytes of the current packet, idle count since last byte, expected TX byte stream.
    logic [7:0]   q_rx[$];
    int           idle = 0;
    logic [255:0] m_mid = '0;
    logic [95:0]  m_data = '0;
    logic         m_wv = 1'b0;
    logic [7:0]   exp_tx[$];
    logic         exp_ovf = 1'b0;

    always @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            q_rx.delete();
            idle = 0;
            m_mid = '0;
            m_data = '0;
            m_wv = 1'b0;
            exp_tx.delete();
            exp_ovf = 1'b0;
        end else begin
            m_wv = 1'b0;
            if (rx_valid) begin
                q_rx.push_back(rx_byte);
                idle = 0;
                if (q_rx.size() == 44) begin
                    for (int i = 0; i < 32; i++) m_mid[255-8*i -: 8] = q_rx[i];
                    for (int i = 0; i < 12; i++) m_data[95-8*i -: 8] = q_rx[32+i];
                    m_wv = 1'b1;
                    q_rx.delete();
                end
            end else begin
                idle++;
                if (q_rx.size() != 0 && idle >= int'(TMO)) q_rx.delete();
            end
        end
    end

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pb = 8'h00;
    int         wv_cnt = 0;
    int         hs_cnt = 0;

    always @(negedge hash_clk) begin
        check("midstate", midstate, m_mid);
        check("data", data, m_data);
        check("work_valid", work_valid, m_wv);
        check("overflow", overflow, exp_ovf);
        if (work_valid) wv_cnt++;
        if (!reset) begin
            if (pv && !pr) begin
                check("hold_valid", tx_valid, 1);
                check("hold_byte", tx_byte, pb);
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got byte %0h expected no byte", tx_byte);
                end else begin
                    check("tx_byte", tx_byte, exp_tx.pop_front());
                end
            end
        end
        pv = tx_valid & ~reset;
        pr = tx_ready;
        pb = tx_byte;
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle_after);
        rx_byte = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (idle_after) tick();
    endtask

    task automatic push_nonce(input logic [31:0] n, input bit accepted);
        golden_nonce = n;
        golden_valid = 1'b1;
        if (accepted) begin
            for (int i = 0; i < 4; i++) exp_tx.push_back(n[8*i +: 8]);
        end
        tick();
        golden_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || tx_valid) && n < 80) begin
            tick();
            n++;
        end
        check(name, exp_tx.size(), 0);
    endtask

    logic [31:0] ov_n [6];
    logic [7:0]  be [4];
    int          base;

    initial begin
        // Reset state
        #3;
        check("rst_midstate", midstate, 0);
        check("rst_data", data, 0);
        check("rst_work_valid", work_valid, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_overflow", overflow, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Full packet 0x00..0x2B with 3 idle cycles between bytes
        for (int i = 0; i < 43; i++) send_byte(8'(i), 3);
        rx_byte = 8'h2B;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("wv_on_44th", work_valid, 1);
        check("pkt_midstate", midstate, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        check("pkt_data", data, 96'h202122232425262728292a2b);
        tick();
        check("wv_one_cycle", work_valid, 0);
        tick();
        check("wv_count_pkt", wv_cnt, 1);

        // Partial packet discarded after exactly TMO idle cycles
        base = wv_cnt;
        for (int i = 0; i < 19; i++) send_byte(8'h77, 0);
        send_byte(8'h77, int'(TMO));
        for (int i = 0; i < 44; i++) send_byte(8'hFF, 0);
        tick();
        check("tmo_midstate", midstate, {256{1'b1}});
        check("tmo_data", data, {96{1'b1}});
        check("tmo_wv_count", wv_cnt, base + 1);

        // Byte arriving on the timeout cycle keeps the packet alive
        base = wv_cnt;
        for (int i = 0; i < 44; i++) send_byte(8'h40 + 8'(i), (i == 9) ? int'(TMO) - 1 : 0);
        tick();
        check("edge_mid_top", midstate[255:248], 8'h40);
        check("edge_data_low", data[7:0], 8'h6B);
        check("edge_wv_count", wv_cnt, base + 1);

        // Single nonce, tx_ready high
        tx_ready = 1'b1;
        be[0] = 8'hEF; be[1] = 8'hBE; be[2] = 8'hAD; be[3] = 8'hDE;
        push_nonce(32'hDEADBEEF, 1'b1);
        check("single_not_yet", tx_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_valid", tx_valid, 1);
            check("single_byte", tx_byte, be[i]);
        end
        tick();
        check("single_done", tx_valid, 0);
        tick();

        // Backpressure for 10 cycles mid-nonce
        push_nonce(32'h11223344, 1'b1);
        tick();
        check("bp_first", tx_byte, 8'h44);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", tx_valid, 1);
            check("bp_hold_byte", tx_byte, 8'h33);
        end
        tx_ready = 1'b1;
        tick();
        check("bp_resume_22", tx_byte, 8'h22);
        tick();
        check("bp_resume_11", tx_byte, 8'h11);
        tick();
        check("bp_done", tx_valid, 0);
        tick();

        // Overflow: one in flight plus four queued, sixth dropped
        tx_ready = 1'b0;
        ov_n[0] = 32'h01020304; ov_n[1] = 32'h11121314; ov_n[2] = 32'h21222324;
        ov_n[3] = 32'h31323334; ov_n[4] = 32'h41424344; ov_n[5] = 32'h51525354;
        for (int i = 0; i < 5; i++) push_nonce(ov_n[i], 1'b1);
        check("ovf_before", overflow, 0);
        push_nonce(ov_n[5], 1'b0);
        exp_ovf = 1'b1;
        check("ovf_after", overflow, 1);
        check("ovf_head_valid", tx_valid, 1);
        check("ovf_head_byte", tx_byte, 8'h04);
        base = hs_cnt;
        tx_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_bytes_sent", hs_cnt - base, 20);
        check("ovf_sticky", overflow, 1);

        // Reset during byte index 2 and mid-packet
        for (int i = 0; i < 10; i++) send_byte(8'h90 + 8'(i), 0);
        push_nonce(32'hCAFEBABE, 1'b1);
        tick();
        tick();
        tick();
        check("rst_pre_idx2", tx_byte, 8'hFE);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_midstate", midstate, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_byte", tx_byte, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_work_valid", work_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", tx_valid, 0);

        base = wv_cnt;
        for (int i = 0; i < 44; i++) send_byte(8'hC0 + 8'(i), 1);
        tick();
        check("post_rst_mid_top", midstate[255:248], 8'hC0);
        check("post_rst_data_low", data[7:0], 8'hEB);
        check("post_rst_wv_count", wv_cnt, base + 1);
        base = hs_cnt;
        push_nonce(32'h0BADF00D, 1'b1);
        drain("post_rst_drain");
        check("post_rst_bytes", hs_cnt - base, 4);
        check("post_rst_ovf", overflow, 0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
